// File: rtl/conv_stream_feeder.sv
// AXI-Stream master feeding conv1D: a weight frame, an idle gap, then a data frame
// read from internal buffers that are loaded through the cfg write port while idle.
module conv_stream_feeder #(
  parameter int DATA_W       = 16,
  parameter int KERNEL_LEN   = 9,
  parameter int MAX_DATA_LEN = 64,
  parameter int GAP_CYCLES   = 2,
  localparam int AW = (MAX_DATA_LEN > 1) ? $clog2(MAX_DATA_LEN) : 1
) (
  input  logic                M_AXIS_ACLK,
  input  logic                M_AXIS_ARESETN,
  input  logic                cfg_wr_en,
  input  logic                cfg_wr_sel,
  input  logic [AW-1:0]       cfg_wr_addr,
  input  logic [DATA_W-1:0]   cfg_wr_data,
  input  logic [AW:0]         data_len,
  input  logic                start,
  output logic                busy,
  output logic                done,
  output logic                M_AXIS_TVALID,
  output logic [DATA_W-1:0]   M_AXIS_TDATA,
  output logic [DATA_W/8-1:0] M_AXIS_TKEEP,
  output logic                M_AXIS_TLAST,
  input  logic                M_AXIS_TREADY
);

  localparam int KW = (KERNEL_LEN > 1) ? $clog2(KERNEL_LEN) : 1;
  localparam int MX = (KERNEL_LEN > MAX_DATA_LEN) ? KERNEL_LEN : MAX_DATA_LEN;
  localparam int IW = (MX > 1) ? $clog2(MX) : 1;
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int LW = AW + 1;

  typedef enum logic [2:0] {S_IDLE, S_SEND_W, S_GAP, S_SEND_D, S_FINISH} state_t;

  state_t            state_q, state_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [GW-1:0]     gap_q, gap_d;
  logic [LW-1:0]     len_q, len_d;
  logic              tvalid_q, tvalid_d;
  logic [DATA_W-1:0] tdata_q, tdata_d;
  logic              tlast_q, tlast_d;
  logic              done_q, done_d;

  logic [DATA_W-1:0] wmem [2**KW];
  logic [DATA_W-1:0] dmem [2**AW];

  logic              wr_ok, wr_w, wr_d, hs, w_last, d_last;
  logic [KW-1:0]     wr_waddr;
  logic [IW-1:0]     idx_inc;
  logic [LW-1:0]     len_in;
  logic [DATA_W-1:0] w_first, w_nxt, d_first, d_nxt;

  assign busy     = (state_q != S_IDLE);
  assign wr_waddr = KW'(cfg_wr_addr);
  assign wr_ok    = cfg_wr_en && !busy;
  assign wr_w     = wr_ok && !cfg_wr_sel && (int'(cfg_wr_addr) < KERNEL_LEN);
  assign wr_d     = wr_ok &&  cfg_wr_sel && (int'(cfg_wr_addr) < MAX_DATA_LEN);

  always_ff @(posedge M_AXIS_ACLK) begin
    if (wr_w) wmem[wr_waddr] <= cfg_wr_data;
    if (wr_d) dmem[cfg_wr_addr] <= cfg_wr_data;
  end

  // A weight-0 write in the start cycle is forwarded so the first beat carries it.
  assign w_first = (wr_w && wr_waddr == '0) ? cfg_wr_data : wmem[KW'(0)];
  assign d_first = dmem[AW'(0)];
  assign idx_inc = idx_q + IW'(1);
  assign w_nxt   = wmem[idx_inc[KW-1:0]];
  assign d_nxt   = dmem[idx_inc[AW-1:0]];
  assign len_in  = (data_len > LW'(MAX_DATA_LEN)) ? LW'(MAX_DATA_LEN) : data_len;
  assign hs      = tvalid_q && M_AXIS_TREADY;
  assign w_last  = (int'(idx_q) == KERNEL_LEN - 1);
  assign d_last  = (int'(idx_q) == int'(len_q) - 1);

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    gap_d    = gap_q;
    len_d    = len_q;
    tvalid_d = tvalid_q;
    tdata_d  = tdata_q;
    tlast_d  = tlast_q;
    done_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d  = S_SEND_W;
          idx_d    = '0;
          len_d    = len_in;
          tvalid_d = 1'b1;
          tdata_d  = w_first;
          tlast_d  = (KERNEL_LEN == 1);
        end
      end
      S_SEND_W: begin
        if (hs) begin
          if (w_last) begin
            tvalid_d = 1'b0;
            tdata_d  = '0;
            tlast_d  = 1'b0;
            idx_d    = '0;
            if (GAP_CYCLES > 0) begin
              state_d = S_GAP;
              gap_d   = '0;
            end else if (len_q == '0) begin
              state_d = S_FINISH;
              done_d  = 1'b1;
            end else begin
              state_d  = S_SEND_D;
              tvalid_d = 1'b1;
              tdata_d  = d_first;
              tlast_d  = (len_q == LW'(1));
            end
          end else begin
            idx_d   = idx_inc;
            tdata_d = w_nxt;
            tlast_d = (int'(idx_inc) == KERNEL_LEN - 1);
          end
        end
      end
      S_GAP: begin
        if (int'(gap_q) == GAP_CYCLES - 1) begin
          gap_d = '0;
          if (len_q == '0) begin
            state_d = S_FINISH;
            done_d  = 1'b1;
          end else begin
            state_d  = S_SEND_D;
            tvalid_d = 1'b1;
            tdata_d  = d_first;
            tlast_d  = (len_q == LW'(1));
          end
        end else begin
          gap_d = gap_q + GW'(1);
        end
      end
      S_SEND_D: begin
        if (hs) begin
          if (d_last) begin
            state_d  = S_FINISH;
            done_d   = 1'b1;
            tvalid_d = 1'b0;
            tdata_d  = '0;
            tlast_d  = 1'b0;
            idx_d    = '0;
          end else begin
            idx_d   = idx_inc;
            tdata_d = d_nxt;
            tlast_d = (int'(idx_inc) == int'(len_q) - 1);
          end
        end
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge M_AXIS_ACLK) begin
    if (!M_AXIS_ARESETN) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      gap_q    <= '0;
      len_q    <= '0;
      tvalid_q <= 1'b0;
      tdata_q  <= '0;
      tlast_q  <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      gap_q    <= gap_d;
      len_q    <= len_d;
      tvalid_q <= tvalid_d;
      tdata_q  <= tdata_d;
      tlast_q  <= tlast_d;
      done_q   <= done_d;
    end
  end

  assign done          = done_q;
  assign M_AXIS_TVALID = tvalid_q;
  assign M_AXIS_TDATA  = tdata_q;
  assign M_AXIS_TLAST  = tlast_q;
  assign M_AXIS_TKEEP  = {(DATA_W/8){tvalid_q}};

endmodule

// File: tb/tb_conv_stream_feeder.sv
// Self-checking bench for conv_stream_feeder: transfer table checked against a beat-queue
// model, reset-abort sequence, and a cycle table for a zero-gap build.
module tb_conv_stream_feeder;
  localparam int K = 9, MAXL = 64, GAP = 2;

  logic clk = 1'b0, rstn = 1'b0;
  logic cfg_wr_en = 0, cfg_wr_sel = 0, start = 0, tready = 0;
  logic [5:0] cfg_wr_addr = '0;
  logic [15:0] cfg_wr_data = '0;
  logic [6:0] data_len = '0;
  logic busy, done, tvalid, tlast;
  logic [15:0] tdata;
  logic [1:0] tkeep;

  logic g_wr_en = 0, g_wr_sel = 0, g_start = 0, g_tready = 1;
  logic [2:0] g_wr_addr = '0;
  logic [15:0] g_wr_data = '0;
  logic [3:0] g_len = '0;
  logic g_busy, g_done, g_tvalid, g_tlast;
  logic [15:0] g_tdata;
  logic [1:0] g_tkeep;

  int checks = 0, errors = 0;
  logic [15:0] wm [K];
  logic [15:0] dm [MAXL];
  logic [15:0] t1 [21] = '{0,0,0,0,1,6,0,2,7,0,3,8,0,4,9,0,5,10,0,0,0};

  conv_stream_feeder #(.DATA_W(16), .KERNEL_LEN(K), .MAX_DATA_LEN(MAXL), .GAP_CYCLES(GAP)) dut (
    .M_AXIS_ACLK(clk), .M_AXIS_ARESETN(rstn), .cfg_wr_en(cfg_wr_en), .cfg_wr_sel(cfg_wr_sel),
    .cfg_wr_addr(cfg_wr_addr), .cfg_wr_data(cfg_wr_data), .data_len(data_len), .start(start),
    .busy(busy), .done(done), .M_AXIS_TVALID(tvalid), .M_AXIS_TDATA(tdata), .M_AXIS_TKEEP(tkeep),
    .M_AXIS_TLAST(tlast), .M_AXIS_TREADY(tready));

  conv_stream_feeder #(.DATA_W(16), .KERNEL_LEN(3), .MAX_DATA_LEN(8), .GAP_CYCLES(0)) dut0 (
    .M_AXIS_ACLK(clk), .M_AXIS_ARESETN(rstn), .cfg_wr_en(g_wr_en), .cfg_wr_sel(g_wr_sel),
    .cfg_wr_addr(g_wr_addr), .cfg_wr_data(g_wr_data), .data_len(g_len), .start(g_start),
    .busy(g_busy), .done(g_done), .M_AXIS_TVALID(g_tvalid), .M_AXIS_TDATA(g_tdata),
    .M_AXIS_TKEEP(g_tkeep), .M_AXIS_TLAST(g_tlast), .M_AXIS_TREADY(g_tready));

  always #5 clk = ~clk;

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic wr(input bit sel, input int addr, input logic [15:0] d);
    cfg_wr_en = 1; cfg_wr_sel = sel; cfg_wr_addr = 6'(addr); cfg_wr_data = d;
    tick();
    cfg_wr_en = 0;
    if (!sel && addr < K) wm[addr] = d;
    if (sel && addr < MAXL) dm[addr] = d;
  endtask

  task automatic wr0(input bit sel, input int addr, input logic [15:0] d);
    g_wr_en = 1; g_wr_sel = sel; g_wr_addr = 3'(addr); g_wr_data = d;
    tick();
    g_wr_en = 0;
  endtask

  task automatic load_t1();
    for (int i = 0; i < K; i++) wr(0, i, 16'(i + 1));
    for (int i = 0; i < 21; i++) wr(1, i, t1[i]);
  endtask

  // Expected stream = all weights then min(len,MAXL) data words; gap/done timing tracked by phase.
  task automatic run_transfer(input int len, input int rmode, input bit wr_start,
                              input int poke, input int exp_db);
    logic [15:0] eq[$];
    bit el[$];
    int eff, phase, idle, cyc, dbeats;
    bit fin, stall, lb, rdy;
    logic [15:0] ptd, ed;
    logic ptl;
    eff = (len > MAXL) ? MAXL : len;
    if (wr_start) wm[0] = 16'h0077;
    for (int i = 0; i < K; i++) begin eq.push_back(wm[i]); el.push_back(i == K - 1); end
    for (int i = 0; i < eff; i++) begin eq.push_back(dm[i]); el.push_back(i == eff - 1); end
    start = 1; data_len = 7'(len);
    if (wr_start) begin
      cfg_wr_en = 1; cfg_wr_sel = 0; cfg_wr_addr = '0; cfg_wr_data = 16'h0077;
    end
    tick();
    start = 0; cfg_wr_en = 0;
    chk("start_accept", {busy, tvalid}, 2'b11);
    phase = 0; idle = 0; dbeats = 0; fin = 0; stall = 0; ptd = '0; ptl = 0;
    for (cyc = 0; cyc < 2000 && !fin; cyc++) begin
      start = 0; cfg_wr_en = 0;
      if (stall) chk("stall_hold", {tvalid, tdata, tlast}, {1'b1, ptd, ptl});
      case (phase)
        1: begin
          if (eff > 0) begin
            if (tvalid) begin chk("gap_len", idle, GAP); phase = 2; end
            else idle++;
          end else if (idle == GAP) begin
            chk("done_len0", done, 1); phase = 4;
          end else idle++;
        end
        3: begin chk("done_pulse", done, 1); phase = 4; end
        4: begin chk("busy_clear", {busy, tvalid, done}, 3'b000); fin = 1; end
        default: ;
      endcase
      if (done && phase != 4) chk("done_spurious", done, 0);
      if (rmode == 0 && (phase == 0 || phase == 2)) chk("no_bubble", tvalid, 1);
      case (rmode)
        0: rdy = 1;
        1: rdy = (cyc % 4 == 0) || (cyc % 4 == 3);
        default: rdy = ($urandom_range(0, 3) != 0);
      endcase
      if (poke >= 0 && cyc == poke) begin
        start = 1; data_len = 7'd5;
        cfg_wr_en = 1; cfg_wr_sel = 1; cfg_wr_addr = 6'd3; cfg_wr_data = 16'hBEEF;
      end
      if (poke >= 0 && cyc == poke + 1) begin
        cfg_wr_en = 1; cfg_wr_sel = 0; cfg_wr_addr = 6'd0; cfg_wr_data = 16'hDEAD;
      end
      tready = rdy;
      if (tvalid && rdy && phase != 4) begin
        if (eq.size() == 0) chk("extra_beat", tvalid, 0);
        else begin
          ed = eq.pop_front();
          lb = el.pop_front();
          chk("beat", {tvalid, tdata, tlast, tkeep}, {1'b1, ed, lb, 2'b11});
          if (phase == 2) dbeats++;
          if (lb) begin phase = (phase == 0) ? 1 : 3; idle = 0; end
        end
      end
      stall = tvalid && !rdy;
      ptd = tdata; ptl = tlast;
      tick();
    end
    tready = 0; start = 0; cfg_wr_en = 0;
    if (!fin) begin
      checks++; errors++;
      $display("FAIL timeout: transfer len=%0d did not complete (phase %0d)", len, phase);
    end
    chk("beats_left", eq.size(), 0);
    chk("data_beats", dbeats, exp_db);
  endtask

  typedef struct {int len; int rmode; bit rnd; bit wrs; int poke; int exp_db;} xfer_t;
  xfer_t xt [11];

  typedef struct packed {logic st; logic [3:0] len; logic tv; logic [15:0] td;
                         logic tl; logic dn; logic bz;} row_t;
  row_t rows [12];

  initial begin
    int n;
    xt[0]  = '{21, 0, 0, 0, -1, 21};
    xt[1]  = '{21, 1, 0, 0, -1, 21};
    xt[2]  = '{0,  0, 0, 0, -1, 0};
    xt[3]  = '{80, 0, 0, 0, -1, 64};
    xt[4]  = '{21, 1, 0, 0, 15, 21};
    xt[5]  = '{21, 0, 0, 0, -1, 21};
    xt[6]  = '{5,  0, 0, 1, -1, 5};
    xt[7]  = '{7,  2, 1, 0, -1, 7};
    xt[8]  = '{64, 2, 1, 0, -1, 64};
    xt[9]  = '{1,  2, 1, 0, -1, 1};
    xt[10] = '{127, 2, 0, 0, -1, 64};

    rows[0]  = '{1'b1, 4'd2, 1'b1, 16'h0011, 1'b0, 1'b0, 1'b1};
    rows[1]  = '{1'b0, 4'd0, 1'b1, 16'h0022, 1'b0, 1'b0, 1'b1};
    rows[2]  = '{1'b0, 4'd0, 1'b1, 16'h0033, 1'b1, 1'b0, 1'b1};
    rows[3]  = '{1'b0, 4'd0, 1'b1, 16'h00A1, 1'b0, 1'b0, 1'b1};
    rows[4]  = '{1'b0, 4'd0, 1'b1, 16'h00A2, 1'b1, 1'b0, 1'b1};
    rows[5]  = '{1'b0, 4'd0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1};
    rows[6]  = '{1'b0, 4'd0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0};
    rows[7]  = '{1'b1, 4'd0, 1'b1, 16'h0011, 1'b0, 1'b0, 1'b1};
    rows[8]  = '{1'b0, 4'd0, 1'b1, 16'h0022, 1'b0, 1'b0, 1'b1};
    rows[9]  = '{1'b0, 4'd0, 1'b1, 16'h0033, 1'b1, 1'b0, 1'b1};
    rows[10] = '{1'b0, 4'd0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1};
    rows[11] = '{1'b0, 4'd0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0};

    rstn = 0;
    repeat (3) tick();
    chk("rst_main", {tvalid, tlast, busy, done, tdata, tkeep}, '0);
    chk("rst_g0", {g_tvalid, g_tlast, g_busy, g_done, g_tdata, g_tkeep}, '0);
    rstn = 1;
    tick();

    for (int a = 0; a < MAXL; a++) wr(1, a, (a < 21) ? t1[a] : 16'($urandom));
    for (int i = 0; i < K; i++) wr(0, i, 16'(i + 1));
    wr(0, 9, 16'hDEAD);
    wr(0, 16, 16'hBEEF);

    foreach (xt[i]) begin
      if (xt[i].rnd) for (int a = 0; a < MAXL; a++) wr(1, a, 16'($urandom));
      run_transfer(xt[i].len, xt[i].rmode, xt[i].wrs, xt[i].poke, xt[i].exp_db);
    end

    // Reset while data beat 5 is on the bus, then a clean full resend.
    load_t1();
    tready = 1; start = 1; data_len = 7'd21;
    tick();
    start = 0;
    n = 0;
    for (int c = 0; c < 200 && n < 13; c++) begin
      if (tvalid) n++;
      tick();
    end
    chk("t3_reach", n, 13);
    chk("t3_beat5", {tvalid, tdata}, {1'b1, dm[4]});
    rstn = 0;
    tick();
    chk("t3_abort", {tvalid, busy, done}, 3'b000);
    rstn = 1;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("t3_quiet", {tvalid, busy, done}, 3'b000);
    end
    run_transfer(21, 0, 0, -1, 21);

    wr0(0, 0, 16'h0011); wr0(0, 1, 16'h0022); wr0(0, 2, 16'h0033);
    wr0(1, 0, 16'h00A1); wr0(1, 1, 16'h00A2);
    foreach (rows[i]) begin
      g_start = rows[i].st; g_len = rows[i].len;
      tick();
      g_start = 0;
      chk($sformatf("g0_row%0d", i),
          {g_tvalid, (g_tvalid ? g_tdata : 16'h0), (g_tvalid ? g_tkeep : 2'b11), g_tlast, g_done, g_busy},
          {rows[i].tv, (rows[i].tv ? rows[i].td : 16'h0), 2'b11, rows[i].tl, rows[i].dn, rows[i].bz});
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
